// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample, result and coefficient-write signals of the FIR tap engine
interface fir_mac_sequencer_if #(
    parameter int DW   = 16,
    parameter int ACCW = 39,
    parameter int AW   = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_sample;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_wdata;

    // master: sample source, result consumer and coefficient loader
    modport master (
        output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR: one multiplier sequenced over TAPS taps per sample
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    parameter int DW   = 16,
    parameter int ACCW = 39,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_mac_sequencer_if.slave    bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   delay_q [TAPS];
    logic [DW-1:0]   coef_q  [TAPS];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   newest_q, newest_d;
    logic [AW-1:0]   tap_q, tap_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            sample_wr;
    logic            coef_wr;
    logic            addr_ok;
    logic [AW-1:0]   rd_idx;
    logic [2*DW-1:0] product;

    // With a power-of-two tap count every address is in range.
    if ((1 << AW) == TAPS) begin : g_addr_pow2
        assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
        assign addr_ok = (int'(bus.coef_addr) < TAPS);
    end

    // Delay-line read index (newest - tap) mod TAPS, valid for any TAPS.
    always_comb begin
        rd_idx = newest_q - tap_q;
        if (newest_q < tap_q) begin
            rd_idx = AW'({1'b0, newest_q} + (AW + 1)'(TAPS) - {1'b0, tap_q});
        end
    end

    assign product = {{DW{1'b0}}, delay_q[rd_idx]} * {{DW{1'b0}}, coef_q[tap_q]};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        newest_d    = newest_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sample_wr   = 1'b0;
        coef_wr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                coef_wr = bus.coef_we & addr_ok;
                if (bus.in_valid) begin
                    sample_wr = 1'b1;
                    newest_d  = wr_ptr_q;
                    wr_ptr_d  = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
                    acc_d     = '0;
                    tap_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + ACCW'(product);
                tap_d = tap_q + AW'(1);
                if (tap_q == LAST_TAP) begin
                    tap_d       = '0;
                    out_data_d  = acc_d;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (sample_wr) begin
                delay_q[wr_ptr_q] <= bus.in_sample;
            end
            if (coef_wr) begin
                coef_q[bus.coef_addr] <= bus.coef_wdata;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - randomized self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int ACCW = 39;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.DW(DW), .ACCW(ACCW), .AW(AW)) bus ();

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: sample history (newest at back) and coefficient table.
    logic [DW-1:0] hist[$];
    logic [DW-1:0] coef_m [TAPS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_out();
        longint unsigned s = 0;
        longint unsigned a, b;
        for (int k = 0; k < TAPS; k++) begin
            if (k < hist.size()) begin
                a = coef_m[k];
                b = hist[hist.size() - 1 - k];
                s += a * b;
            end
        end
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.coef_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        for (int k = 0; k < TAPS; k++) coef_m[k] = '0;
    endtask

    task automatic write_coef(input int addr, input logic [DW-1:0] v);
        bus.coef_we = 1'b1; bus.coef_addr = AW'(addr); bus.coef_wdata = v;
        @(negedge clk);
        bus.coef_we = 1'b0;
        if (addr < TAPS) coef_m[addr] = v;
    endtask

    // wr_mode: 0 none, 1 coef write during RUN (must be dropped), 2 write in the acceptance cycle
    task automatic send(input logic [DW-1:0] x, input int stall, input int wr_mode,
                        input int wr_addr, input logic [DW-1:0] wr_val,
                        output logic [63:0] obs, output int waited);
        int cyc;
        logic [63:0] exp, held;
        bus.in_valid = 1'b1; bus.in_sample = x; waited = 0;
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        if (wr_mode == 2) begin
            bus.coef_we = 1'b1; bus.coef_addr = AW'(wr_addr); bus.coef_wdata = wr_val;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.coef_we = 1'b0;
        if (wr_mode == 2) coef_m[wr_addr] = wr_val;
        hist.push_back(x);
        if (hist.size() > TAPS) void'(hist.pop_front());
        exp = ref_out();
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            bus.coef_we = (wr_mode == 1 && cyc == 2);
            if (bus.coef_we) begin
                bus.coef_addr = AW'(wr_addr); bus.coef_wdata = wr_val;
                check("busy_in_run", busy, 1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.coef_we = 1'b0;
        check("latency", cyc, TAPS);
        check("out_data", bus.out_data, exp);
        obs = bus.out_data;
        held = obs;
        bus.out_ready = 1'b0;
        bus.in_valid = (stall > 0);
        bus.in_sample = 16'h1234;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, held);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_valid", bus.out_valid, 0);
        check("post_hs_in_ready", bus.in_ready, 1);
        check("post_hs_busy", busy, 0);
        check("post_hs_hold", bus.out_data, held);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] obs;
        int w, last_acc, n_acc;
        logic prev_ov;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
        do_reset();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);

        // Impulse response
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 16'd1 : 16'd0, 0, 0, 0, '0, obs, w);
            check("impulse", obs, (i < TAPS) ? 64'(i + 1) : 64'd0);
        end

        // Full-scale sum
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'hFFFF);
        for (int i = 1; i <= TAPS; i++) begin
            send(16'hFFFF, 0, 0, 0, '0, obs, w);
            check("fullscale", obs, 64'(i) * 64'hFFFE0001);
        end
        check("fullscale_max", obs, 64'h7_FFF0_0008);

        // Backpressure: 0x1234 presented during DONE must wait, then go in at once
        send(16'h0042, 5, 0, 0, '0, obs, w);
        send(16'h1234, 0, 0, 0, '0, obs, w);
        check("bp_accept_immediate", w, 0);

        // Coefficient lockout
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'($urandom_range(1, 16'hFFFF)));
        send(DW'($urandom_range(1, 16'hFFFF)), 0, 1, 0, 16'h00FF, obs, w);
        send(DW'($urandom_range(1, 16'hFFFF)), 0, 0, 0, '0, obs, w);
        write_coef(0, 16'h00FF);
        send(DW'($urandom_range(1, 16'hFFFF)), 0, 0, 0, '0, obs, w);

        // Reset mid-RUN at tap 3
        bus.in_valid = 1'b1; bus.in_sample = 16'h0077;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_data", bus.out_data, 0);
        rst = 1'b0;
        hist.delete();
        for (int k = 0; k < TAPS; k++) coef_m[k] = '0;
        send(16'd1, 0, 0, 0, '0, obs, w);
        check("midrst_impulse", obs, 0);

        // Randomized traffic with coefficient writes in every position
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'($urandom));
        for (int i = 0; i < 30; i++) begin
            send(DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, TAPS - 1), DW'($urandom), obs, w);
        end

        // Throughput
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'($urandom));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        last_acc = -1; n_acc = 0; prev_ov = 1'b0;
        begin
            logic [63:0] exp_q[$];
            for (int t = 0; t < 70; t++) begin
                bus.in_sample = DW'($urandom);
                if (bus.in_ready) begin
                    if (last_acc >= 0) check("accept_interval", t - last_acc, TAPS + 2);
                    last_acc = t;
                    n_acc++;
                    hist.push_back(bus.in_sample);
                    if (hist.size() > TAPS) void'(hist.pop_front());
                    exp_q.push_back(ref_out());
                end
                if (bus.out_valid) begin
                    check("ov_single", prev_ov, 0);
                    check("ov_distance", t - last_acc, TAPS + 1);
                    check("thr_data", bus.out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD);
                end
                prev_ov = bus.out_valid;
                @(negedge clk);
            end
        end
        check("thr_accept_count", n_acc >= 6, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR tap engine. It accepts one input sample per handshake, stores it in a TAPS-deep circular delay line, and sequences a single 16x16 unsigned multiplier and a 39-bit accumulator across all taps. It then presents the filtered result on a valid/ready output. It sits between the sample source and the downstream consumer, and it owns the coefficient RAM, which is loaded through a configuration write port.

## Interface
- TAPS, 8: number of filter taps; legal range 2..128, so 7 guard bits are enough.
- DW, 16: sample and coefficient width.
- ACCW, 39: accumulator and result width; must be at least 2*DW+7.
- AW, $clog2(TAPS): width of the tap index and coefficient address.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_sample  in  DW  unsigned input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACCW  filter result, sum over k of c[k]*x[n-k].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index k.
- coef_wdata  in  DW  unsigned coefficient value.
- busy  out  1  high in RUN and DONE.

## Operation
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0. Delay line all zeros, coefficients all zeros, wr_ptr=0, tap=0, acc=0.
- FSM states are IDLE, RUN and DONE.
- IDLE behaviour:
  - in_ready=1.
  - When in_valid=1: write in_sample to delay[wr_ptr], set newest=wr_ptr, advance wr_ptr (wrapping TAPS-1 to 0), clear acc, set tap=0, go to RUN.
- RUN behaviour:
  - in_ready=0.
  - Each cycle: acc <= acc + delay[(newest - tap) mod TAPS] * coef[tap], then tap <= tap+1.
  - The cycle with tap=TAPS-1 performs the last accumulate. On that edge, out_data <= final sum, out_valid <= 1, go to DONE.
  - c[0] always multiplies the newest sample.
- DONE behaviour:
  - out_valid=1 and out_data is held stable.
  - When out_ready=1: out_valid <= 0, go to IDLE.
  - in_valid is ignored in DONE.
- out_data keeps its last value after the handshake, until the next result overwrites it.
- Arithmetic is unsigned. Each product is zero-extended from 2*DW to ACCW bits, with no saturation. With ACCW ≥ 2*DW+7 and TAPS ≤ 128, the sum cannot overflow.
- Coefficient writes:
  - Accepted only in IDLE. coef_we in RUN or DONE is dropped silently.
  - A write with coef_addr ≥ TAPS is dropped.
  - A write and a sample acceptance in the same IDLE cycle: the write is applied on that edge, and the new coefficient is used by the computation that starts.
- Delay-line wrap: modular index arithmetic. Before TAPS samples have been received, the unwritten slots are zero (reset value).
- Reset mid-operation (RUN or DONE): any pending result is discarded. All state returns to reset values, including the delay line and coefficients.

## Timing
- Sample acceptance happens at edge E0 (IDLE, in_valid=1).
- Accumulates occur at edges E1..E_TAPS. out_valid is high from E_TAPS, i.e. TAPS cycles after acceptance.
- Minimum period per sample, with out_ready held 1: TAPS+2 cycles.
  - 1 IDLE cycle.
  - TAPS RUN cycles.
  - 1 DONE cycle.
- Earliest next acceptance is edge E_(TAPS+2).
- in_ready depends only on state, with no combinational path from in_valid. out_valid is a registered output.
- No combinational path from out_ready to in_ready; re-acceptance is delayed by the IDLE cycle.

## Test plan
- **Impulse response.** Load coef[k]=k+1 for k=0..7. Send sample 1, then seven 0s. Outputs must be 1,2,3,4,5,6,7,8. A ninth sample of 0 must give 0.
- **Full-scale sum.** Load all coef=0xFFFF and send eight samples of 0xFFFF. The eighth output must be 0x7_FFF0_0008 with no wrap. Earlier outputs are k*0xFFFE0001 for k=1..7.
- **Backpressure.** Hold out_ready=0 for 5 cycles in DONE while in_valid=1 and sample 0x1234 is presented. Required:
  - out_valid stays 1 and out_data stays stable.
  - in_ready stays 0 and the sample is not consumed.
  - After out_ready=1, in_ready rises one cycle later and 0x1234 is accepted.
- **Coefficient lockout.** During RUN, write coef[0]=0x00FF. Required:
  - busy=1 and the write is dropped.
  - The current result and the next result both use the old coef[0].
  - The same write issued in IDLE takes effect.
- **Reset mid-RUN.** Assert rst at tap 3. Required:
  - Next cycle: out_valid=0, in_ready=1, out_data=0.
  - A subsequent impulse with unloaded coefficients gives 0.
- **Throughput.** Hold in_valid=1 and out_ready=1 with TAPS=8. Required:
  - in_ready pulses once every 10 cycles.
  - out_valid pulses one cycle every 10 cycles, 8 cycles after each acceptance.
